// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with stall, flush, bubble and optional perf counters (IF_ID_PERF_EN).
module if_id_reg #(
  parameter logic [31:0] RESET_ADDR = 32'h00000000,
  parameter logic [31:0] NOP_INST   = 32'h00000013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  input  logic        i_valid,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_inst,
  output logic        o_valid,
  output logic        o_misaligned,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);
  logic [31:0] pc_q, pc_d, inst_q, inst_d;
  logic        valid_q, valid_d, mis_q, mis_d;
  logic        load;
  always_comb begin
    load    = !i_flush && !i_stall;
    pc_d    = load ? i_pc : pc_q;
    inst_d  = i_flush ? NOP_INST : load ? i_inst : inst_q;
    valid_d = i_flush ? 1'b0 : load ? i_valid : valid_q;
    mis_d   = i_flush ? 1'b0 : load ? (i_pc[1:0] != 2'b00) : mis_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q    <= RESET_ADDR;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end
  assign o_pc         = pc_q;
  assign o_pc_plus4   = pc_q + 32'd4;
  assign o_inst       = valid_q ? inst_q : NOP_INST;
  assign o_valid      = valid_q;
  assign o_misaligned = valid_q & mis_q;
`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  // only live entries count; stalled or flushed bubbles are free
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'b0, !i_flush && i_stall && valid_q};
    flush_cnt_d = flush_cnt_q + {31'b0, i_flush && valid_q};
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_stall_cnt = 32'h0;
  assign o_flush_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_if_id_reg.sv
// tb_if_id_reg: directed vector table plus randomized run against a behavioural model of if_id_reg.
module tb_if_id_reg;
`ifdef IF_ID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] RST_PC = 32'h00000000;
  logic        clk = 1'b0;
  logic        rst = 1'b0, valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] pc = 32'h0, inst = 32'h0;
  logic [31:0] o_pc, o_pc_plus4, o_inst, o_stall_cnt, o_flush_cnt;
  logic        o_valid, o_misaligned;
  int          n_tests = 0, n_fail = 0;
  // behavioural model: the instruction slot held for decode
  logic [31:0] m_pc, m_inst, m_s, m_f;
  logic        m_live, m_odd;

  if_id_reg dut (
    .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_inst(inst), .i_valid(valid),
    .i_stall(stall), .i_flush(flush), .o_pc(o_pc), .o_pc_plus4(o_pc_plus4),
    .o_inst(o_inst), .o_valid(o_valid), .o_misaligned(o_misaligned),
    .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic [31:0] pc, inst; logic valid, stall, flush;
    logic [31:0] e_pc, e_inst; logic e_valid, e_mis; logic [31:0] e_s, e_f;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_pc = RST_PC; m_inst = NOP; m_live = 1'b0; m_odd = 1'b0; m_s = 0; m_f = 0;
    end else if (flush) begin
      if (m_live) m_f++;
      m_live = 1'b0; m_inst = NOP; m_odd = 1'b0;
    end else if (stall) begin
      if (m_live) m_s++;
    end else begin
      m_pc = pc; m_inst = inst; m_live = valid; m_odd = (pc % 4) != 0;
    end
  endtask

  task automatic apply(input logic r, input logic [31:0] p, input logic [31:0] i,
                       input logic v, input logic s, input logic f);
    rst = r; pc = p; inst = i; valid = v; stall = s; flush = f;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model();
    chk("pc", o_pc, m_pc);
    chk("pc_plus4", o_pc_plus4, m_pc + 32'd4);
    chk("inst", o_inst, m_live ? m_inst : NOP);
    chk("valid", {31'b0, o_valid}, {31'b0, m_live});
    chk("misaligned", {31'b0, o_misaligned}, {31'b0, m_live && m_odd});
    chk("stall_cnt", o_stall_cnt, PERF ? m_s : 32'h0);
    chk("flush_cnt", o_flush_cnt, PERF ? m_f : 32'h0);
  endtask

  vec_t tbl[16];

  initial begin
    tbl = '{
      '{1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, NOP, 1'b0, 1'b0, 32'd0, 32'd0},
      '{1'b0, 32'h100, 32'h00500093, 1'b1, 1'b0, 1'b0, 32'h100, 32'h00500093, 1'b1, 1'b0, 32'd0, 32'd0},
      '{1'b0, 32'h200, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h100, 32'h00500093, 1'b1, 1'b0, 32'd1, 32'd0},
      '{1'b0, 32'h204, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 32'h100, 32'h00500093, 1'b1, 1'b0, 32'd2, 32'd0},
      '{1'b0, 32'h208, 32'h12345678, 1'b1, 1'b1, 1'b0, 32'h100, 32'h00500093, 1'b1, 1'b0, 32'd3, 32'd0},
      '{1'b0, 32'h20C, 32'hABCDEF01, 1'b1, 1'b1, 1'b1, 32'h100, NOP, 1'b0, 1'b0, 32'd3, 32'd1},
      '{1'b0, 32'h210, 32'h0, 1'b1, 1'b1, 1'b0, 32'h100, NOP, 1'b0, 1'b0, 32'd3, 32'd1},
      '{1'b0, 32'hFFFFFFFC, 32'h11111111, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h11111111, 1'b1, 1'b0, 32'd3, 32'd1},
      '{1'b0, 32'h202, 32'h22222222, 1'b1, 1'b0, 1'b0, 32'h202, 32'h22222222, 1'b1, 1'b1, 32'd3, 32'd1},
      '{1'b0, 32'h300, 32'h33333333, 1'b0, 1'b0, 1'b0, 32'h300, NOP, 1'b0, 1'b0, 32'd3, 32'd1},
      '{1'b0, 32'h204, 32'h44444444, 1'b1, 1'b0, 1'b0, 32'h204, 32'h44444444, 1'b1, 1'b0, 32'd3, 32'd1},
      '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h204, 32'h44444444, 1'b1, 1'b0, 32'd4, 32'd1},
      '{1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, NOP, 1'b0, 1'b0, 32'd0, 32'd0},
      '{1'b0, 32'h8, 32'h55555555, 1'b1, 1'b0, 1'b0, 32'h8, 32'h55555555, 1'b1, 1'b0, 32'd0, 32'd0},
      '{1'b0, 32'hC, 32'h66666666, 1'b1, 1'b0, 1'b1, 32'h8, NOP, 1'b0, 1'b0, 32'd0, 32'd1},
      '{1'b0, 32'h1, 32'h00000077, 1'b1, 1'b0, 1'b0, 32'h1, 32'h00000077, 1'b1, 1'b1, 32'd0, 32'd1}
    };
    for (int k = 0; k < 16; k++) begin
      apply(tbl[k].rst, tbl[k].pc, tbl[k].inst, tbl[k].valid, tbl[k].stall, tbl[k].flush);
      chk($sformatf("v%0d_pc", k), o_pc, tbl[k].e_pc);
      chk($sformatf("v%0d_pc_plus4", k), o_pc_plus4, tbl[k].e_pc + 32'd4);
      chk($sformatf("v%0d_inst", k), o_inst, tbl[k].e_inst);
      chk($sformatf("v%0d_valid", k), {31'b0, o_valid}, {31'b0, tbl[k].e_valid});
      chk($sformatf("v%0d_mis", k), {31'b0, o_misaligned}, {31'b0, tbl[k].e_mis});
      chk($sformatf("v%0d_stall_cnt", k), o_stall_cnt, PERF ? tbl[k].e_s : 32'h0);
      chk($sformatf("v%0d_flush_cnt", k), o_flush_cnt, PERF ? tbl[k].e_f : 32'h0);
    end
    // wrap of pc+4 from the top of the address space
    apply(1'b0, 32'hFFFFFFFC, 32'h0000AAAA, 1'b1, 1'b0, 1'b0);
    chk("wrap_pc_plus4", o_pc_plus4, 32'h00000000);
    apply(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_model();
    for (int k = 0; k < 500; k++) begin
      apply($urandom_range(0, 49) == 0, $urandom, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      check_model();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 Parameter RESET_ADDR, default 32'h00000000, PC value loaded into the register on reset.
REQ-002 Parameter NOP_INST, default 32'h00000013 (addi x0,x0,0), instruction word presented for any bubble.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_pc  input  32  PC of the instruction currently fetched.
REQ-006 i_inst  input  32  instruction word fetched at i_pc.
REQ-007 i_valid  input  1  fetch output is a real instruction.
REQ-008 i_stall  input  1  decode cannot accept; hold contents.
REQ-009 i_flush  input  1  redirect taken; discard held instruction.
REQ-010 o_pc  output  32  registered PC presented to decode.
REQ-011 o_pc_plus4  output  32  o_pc + 4, modulo 2^32.
REQ-012 o_inst  output  32  registered instruction, or NOP_INST when o_valid is 0.
REQ-013 o_valid  output  1  register holds a live instruction.
REQ-014 o_misaligned  output  1  registered flag, i_pc[1:0] != 0 at capture; qualified by o_valid.
REQ-015 o_stall_cnt  output  32  count of cycles held by stall (see Configuration).
REQ-016 o_flush_cnt  output  32  count of flushes that killed a valid entry (see Configuration).

Function
REQ-017 Internal state: pc_q, inst_q, valid_q, mis_q, plus counters; all outputs derive from registered state only (no i_* to o_* combinational path).
REQ-018 Per-edge update priority: reset > flush > stall > load.
REQ-019 Load (no reset, flush, or stall): pc_q<=i_pc, inst_q<=i_inst, valid_q<=i_valid, mis_q<=(i_pc[1:0]!=0).
REQ-020 Stall only: all of pc_q, inst_q, valid_q, mis_q hold; stalled values remain on the outputs for any number of cycles.
REQ-021 Flush (with or without stall): valid_q<=0, inst_q<=NOP_INST, mis_q<=0, pc_q holds.
REQ-022 Latency: one cycle; a value captured at edge N is visible on the outputs after edge N.
REQ-023 o_inst = valid_q ? inst_q : NOP_INST; o_misaligned = valid_q & mis_q.
REQ-024 o_pc_plus4 wraps: pc_q=32'hFFFFFFFC gives 32'h00000000.
REQ-025 Load with i_valid=0 produces a bubble: o_valid=0, o_inst=NOP_INST, o_pc=i_pc.
REQ-026 Stall on an empty (o_valid=0) register holds the bubble and does not count a stall cycle.

Reset
REQ-027 When i_rst=1 at an edge: pc_q<=RESET_ADDR, inst_q<=NOP_INST, valid_q<=0, mis_q<=0, counters<=0, regardless of i_stall or i_flush.
REQ-028 After reset: o_pc=RESET_ADDR, o_pc_plus4=RESET_ADDR+4, o_inst=NOP_INST, o_valid=0, o_misaligned=0, o_stall_cnt=0, o_flush_cnt=0.
REQ-029 Reset asserted mid-stall or mid-flush discards the held instruction; the first post-reset load proceeds normally.

Configuration
REQ-030 Macro IF_ID_PERF_EN compiles in the performance counters.
REQ-031 With IF_ID_PERF_EN defined: o_stall_cnt increments by 1 on each edge where stall applies (no reset, no flush, i_stall=1, valid_q=1); o_flush_cnt increments by 1 on each edge where i_flush=1, i_rst=0 and valid_q=1; both wrap from 32'hFFFFFFFF to 0.
REQ-032 Without IF_ID_PERF_EN: no counter registers exist; o_stall_cnt and o_flush_cnt are tied to 32'h0; all other behaviour is identical.

Verification
REQ-033 Reset, then load i_pc=32'h100, i_inst=32'h00500093, i_valid=1 -> next cycle o_pc=32'h100, o_pc_plus4=32'h104, o_inst=32'h00500093, o_valid=1.
REQ-034 Hold i_stall=1 for 3 cycles while the inputs change -> outputs stay at pc 32'h100 and inst 32'h00500093; o_stall_cnt=3 (PERF_EN builds).
REQ-035 Assert i_flush=1 and i_stall=1 together -> o_valid=0, o_inst=32'h00000013, o_pc=32'h100; o_flush_cnt=1; o_stall_cnt unchanged.
REQ-036 Load i_pc=32'hFFFFFFFC, then i_pc=32'h202 -> first o_pc_plus4=32'h0 and o_misaligned=0; second o_misaligned=1.
REQ-037 Assert i_rst with i_stall=1 while valid_q=1 -> o_pc=RESET_ADDR, o_valid=0, counters 0; non-PERF build reads 0 counters throughout.
